// File: rtl/trace_buffer.sv
// trace_buffer: PC-triggered retire trace capture into a DEPTH-entry FIFO
// with a valid/ready drain port, overflow drop counting and flush.
module trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_en,
    input  logic [31:0]              prog_count,
    input  logic [5:0]               instr_opcode,
    input  logic [4:0]               write_reg_addr,
    input  logic [31:0]              write_reg_data,
    input  logic                     arm,
    input  logic                     flush,
    input  logic [31:0]              trigger_pc,
    input  logic [CNT_W-1:0]         post_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [5:0]               out_opcode,
    output logic [4:0]               out_waddr,
    output logic [31:0]              out_wdata,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [15:0]              dropped_count
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_dropped;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [AW:0]        r_fill;
    logic [74:0]        r_mem [DEPTH];

    logic               w_arm;
    logic               w_trig;
    logic               w_att;
    logic               w_full;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    logic               w_last;
    logic [CNT_W-1:0]   w_post;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [74:0]        w_head;

    // arm is a no-op while already ARMED, so a held arm cannot restart the search
    assign w_arm     = arm && (r_state != ARMED);
    assign w_trig    = !w_arm && (r_state == ARMED) && sample_en && (prog_count == trigger_pc);
    assign w_att     = w_trig || (!w_arm && (r_state == CAPTURE) && sample_en);
    assign w_post    = (post_count == '0) ? CNT_W'(1) : post_count;
    assign w_cnt_nxt = w_trig ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_last    = w_cnt_nxt >= w_post;
    assign w_full    = r_fill == (AW+1)'(DEPTH);
    assign w_pop     = (r_fill != '0) && out_ready;
    assign w_push    = w_att && (!w_full || w_pop);
    assign w_drop    = w_att && w_full && !w_pop && !flush;
    assign w_head    = r_mem[r_rd_ptr];

    assign out_valid     = r_fill != '0;
    assign {out_pc, out_opcode, out_waddr, out_wdata} = out_valid ? w_head : '0;
    assign state         = r_state;
    assign fill_level    = r_fill;
    assign dropped_count = r_dropped;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_dropped <= '0;
        end else if (w_arm) begin
            r_state   <= ARMED;
            r_cnt     <= '0;
            r_dropped <= '0;
        end else begin
            if (w_att) begin
                r_cnt   <= w_cnt_nxt;
                r_state <= w_last ? DONE : CAPTURE;
            end
            if (w_drop && r_dropped != 16'hFFFF)
                r_dropped <= r_dropped + 16'd1;
        end
    end

    // flush wins over any push or pop in the same cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_fill <= r_fill + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !flush)
            r_mem[r_wr_ptr] <= {prog_count, instr_opcode, write_reg_addr, write_reg_data};
    end
endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, 8, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter CNT_W, 8, width of post_count and the capture counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port sample_en  input  1  processor retire record valid this cycle (driven from reg_write).
REQ-006 SHALL have port prog_count  input  32  PC of the retiring instruction.
REQ-007 SHALL have port instr_opcode  input  6  opcode of the retiring instruction.
REQ-008 SHALL have port write_reg_addr  input  5  destination register.
REQ-009 SHALL have port write_reg_data  input  32  value written to the destination register.
REQ-010 SHALL have port arm  input  1  one-cycle request to start a new trigger search.
REQ-011 SHALL have port flush  input  1  empties the FIFO.
REQ-012 SHALL have port trigger_pc  input  32  PC that starts capture.
REQ-013 SHALL have port post_count  input  CNT_W  number of records to capture, trigger record included.
REQ-014 SHALL have ports out_valid output 1, out_ready input 1, out_pc output 32, out_opcode output 6, out_waddr output 5, out_wdata output 32  FIFO head with valid/ready handshake.
REQ-015 SHALL have port state  output  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
REQ-016 SHALL have ports fill_level output clog2(DEPTH)+1 and dropped_count output 16.

Function
REQ-017 SHALL leave IDLE only on arm=1, going to ARMED.
REQ-018 SHALL move ARMED->CAPTURE on an edge where sample_en=1 and prog_count==trigger_pc, and SHALL push that trigger record.
REQ-019 SHALL attempt one push per sample_en=1 edge in CAPTURE, and per attempt SHALL increment a capture counter that starts at 1 for the trigger record.
REQ-020 SHALL enter DONE on the edge where the capture counter reaches post_count; post_count=0 SHALL behave as 1, so the trigger record alone finishes capture.
REQ-021 SHALL, on arm=1 in IDLE, CAPTURE or DONE, go to ARMED and clear the capture counter and dropped_count; FIFO contents SHALL be kept, and arm in ARMED SHALL have no effect.
REQ-022 SHALL accept a pop when out_valid=1 and out_ready=1.
REQ-023 SHALL drive out_valid=1 exactly when fill_level is non-zero.
REQ-024 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-025 SHALL make a record pushed at edge k visible on out_* at edge k (1-cycle latency, out_valid high in cycle k+1), also when the FIFO was empty.
REQ-026 SHALL, when full with no pop in the same cycle, drop the push attempt: FIFO unchanged, dropped_count incremented and saturating at 0xFFFF, attempt still counted toward post_count.
REQ-027 SHALL, when full with a pop and a push in the same cycle, accept both and keep fill_level unchanged.
REQ-028 SHALL, when empty with a push, ignore out_ready.
REQ-029 SHALL wrap read and write pointers modulo DEPTH.
REQ-030 SHALL keep fill_level in 0..DEPTH.
REQ-031 SHALL give flush=1 priority over push and pop in the same cycle: fill_level=0, pointers=0, state and dropped_count unchanged.
REQ-032 SHALL ignore sample_en in IDLE and DONE.

Reset
REQ-033 SHALL, on rst=0 regardless of clk, force: state=IDLE, both pointers=0, fill_level=0, out_valid=0, out_pc/out_opcode/out_waddr/out_wdata=0, dropped_count=0, capture counter=0.
REQ-034 SHALL, on reset asserted mid-CAPTURE, discard all records; after release no capture SHALL occur until a new arm.

Verification
REQ-035 Basic: arm, trigger_pc=0x0C, post_count=3, retires at PCs 0x04,0x08,0x0C,0x10,0x14,0x18 -> records 0x0C,0x10,0x14 only; state DONE the edge after 0x14; out_ready=1 drains in order.
REQ-036 Overflow: DEPTH=8, post_count=12, out_ready=0 -> fill_level=8, dropped_count=4, DONE; drained head is the trigger record.
REQ-037 Full with simultaneous pop and push -> fill_level stays 8; FIFO order preserved across pointer wrap.
REQ-038 Backpressure: out_ready toggled 1-0-1 on a 3-entry FIFO -> out_* stable while out_ready=0, no duplicates, no loss.
REQ-039 Flush and push in the same cycle -> fill_level=0, out_valid=0, state unchanged.
REQ-040 Reset mid-CAPTURE, then 20 retires containing trigger_pc with no arm -> state IDLE, out_valid=0, dropped_count=0.
